// File: rtl/shift_control.sv
// ---------------------------------------------------------------------------
// shift_control
//
// Sequencing controller for the serial logic processor datapath. It sits
// between the switch/button front end and the A/B shift registers. It runs
// N_BITS shift cycles per Execute request. It also supports abort,
// auto-repeat, busy/done status and a live shift counter.
//
// Optional feature macro: SHIFT_CTRL_STEP_EN
//   When defined, the module has a Step input. A shift happens, and the
//   counter advances, only on SHIFT cycles where Step = 1. When the macro is
//   undefined, the module behaves as if Step were tied high.
//
// Parameters
//   N_BITS       shift cycles per run (1..255)
//   CNT_W        counter width, derived from N_BITS (do not override)
//
// Ports
//   Clk          system clock, rising edge
//   Reset_n      asynchronous active-low reset
//   LoadA/LoadB  load requests from the front end
//   Execute      run request (level)
//   Abort        cancel the current run (level, only honoured in SHIFT)
//   Repeat       auto-repeat mode select
//   Step         per-cycle shift qualifier (SHIFT_CTRL_STEP_EN builds only)
//   Ld_A/Ld_B    load strobes, live only in IDLE
//   Shift_En     shift enable to the A/B registers
//   Busy         state is not IDLE
//   Done         one-cycle pulse on the first HOLD cycle of each run
//   Shift_Count  shifts completed in the current run
// ---------------------------------------------------------------------------
module shift_control #(
  parameter int N_BITS = 8,
  parameter int CNT_W  = $clog2(N_BITS + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             LoadA,
  input  logic             LoadB,
  input  logic             Execute,
  input  logic             Abort,
  input  logic             Repeat,
`ifdef SHIFT_CTRL_STEP_EN
  input  logic             Step,
`endif
  output logic             Ld_A,
  output logic             Ld_B,
  output logic             Shift_En,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Shift_Count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Count value seen during the final shift cycle of a run.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BITS - 1);

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             done_q;
  logic             step_w;
  logic             last_shift;

`ifdef SHIFT_CTRL_STEP_EN
  assign step_w = Step;
`else
  assign step_w = 1'b1;
`endif

  assign count_d    = count_q + CNT_W'(1);
  assign last_shift = (count_q == LAST_CNT);

  // Single FSM process. Abort is checked before the final-shift exit, so an
  // abort on the last cycle still cancels the run without a Done pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          count_q <= '0;
          if (Execute) begin
            state_q <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (Abort) begin
            state_q <= ST_IDLE;
            count_q <= '0;
          end else if (step_w) begin
            count_q <= count_d;
            if (last_shift) begin
              state_q <= ST_HOLD;
              done_q  <= 1'b1;
            end
          end
        end

        ST_HOLD: begin
          // Holding here while Execute stays high gives one run per press
          // unless auto-repeat is selected.
          if (!Execute) begin
            state_q <= ST_IDLE;
            count_q <= '0;
          end else if (Repeat) begin
            state_q <= ST_SHIFT;
            count_q <= '0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  // Load strobes follow the requests with zero latency, gated by IDLE only.
  assign Ld_A        = (state_q == ST_IDLE) & LoadA;
  assign Ld_B        = (state_q == ST_IDLE) & LoadB;
  // Shift_En drops in the abort cycle itself, so the shifts performed match
  // the count shown in that cycle.
  assign Shift_En    = (state_q == ST_SHIFT) & ~Abort & step_w;
  assign Busy        = (state_q != ST_IDLE);
  assign Done        = done_q;
  assign Shift_Count = count_q;

endmodule
